nn_input_feeder: RTL and testbench

Buffers input sample pairs (x1, x2) in Q8.8 fixed point and streams them into the first network layer's accumulator load ports (`acc_data_nn_in1`/`acc_data_nn_in2` and their valids). Lane 2 is skewed one cycle behind lane 1 to match the systolic row offset. The block sits directly upstream of the two-neuron layer. It is loaded by the host/testbench through a valid/ready write port and drained on a `start` pulse.

---
 rtl/nn_feeder_pkg.sv | 24 ++
 rtl/nn_input_feeder_if.sv | 43 ++++
 rtl/nn_feeder_mem.sv | 47 ++++
 rtl/nn_input_feeder.sv | 157 +++++++++++++++
 tb/tb_nn_input_feeder.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_feeder_pkg.sv
// rtl/nn_feeder_pkg.sv - shared types and constants for the NN input feeder
package nn_feeder_pkg;

  // Feeder sequencing: load in IDLE, emit lane 1 in STREAM, finish the skewed
  // lane 2 in DRAIN, pulse done out of DONE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

  localparam int FEEDER_DATA_WIDTH = 16;

  // Q8.8 reference values
  localparam logic [15:0] Q_ONE  = 16'h0100;
  localparam logic [15:0] Q_ZERO = 16'h0000;

  // Address width for a power-of-two buffer, never below one bit.
  function automatic int feeder_ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/nn_input_feeder_if.sv
// rtl/nn_input_feeder_if.sv - write port, stream control and layer-load bundle
interface nn_input_feeder_if #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Host write port
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data1;
  logic [DATA_WIDTH-1:0] wr_data2;

  // Stream control
  logic                  start;
  logic                  flush;

  // Layer accumulator load lanes
  logic [DATA_WIDTH-1:0] out_data1;
  logic                  out_valid1;
  logic [DATA_WIDTH-1:0] out_data2;
  logic                  out_valid2;

  // Status
  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      count;

  // Host / stimulus side
  modport master (
    output wr_valid, wr_data1, wr_data2, start, flush,
    input  wr_ready, out_data1, out_valid1, out_data2, out_valid2,
    input  busy, done, count
  );

  // Feeder side
  modport slave (
    input  wr_valid, wr_data1, wr_data2, start, flush,
    output wr_ready, out_data1, out_valid1, out_data2, out_valid2,
    output busy, done, count
  );

endinterface

// File: rtl/nn_feeder_mem.sv
// rtl/nn_feeder_mem.sv - sample-pair register storage, one write port, one registered read port
module nn_feeder_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  // Read register only loads on a read, so the lane holds its last beat.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // Storage array: entries are only read after being written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read data register is reset so downstream lanes start at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/nn_input_feeder.sv
// rtl/nn_input_feeder.sv - buffered Q8.8 pair feeder for the first layer; NN_FEEDER_REPLAY_EN enables non-popping replay
module nn_input_feeder
  import nn_feeder_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = FEEDER_DATA_WIDTH
) (
  input logic               clk,
  input logic               rst,
  nn_input_feeder_if.slave  bus
);

  localparam int PTR_W = feeder_ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  feeder_state_t           state_q, state_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        strm_ptr_q, strm_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        beats_q, beats_d;
  logic                    valid1_q, valid1_d;
  logic                    valid2_q, valid2_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   data2_q, data2_d;

  logic                    idle;
  logic                    full;
  logic                    wr_acc;
  logic                    rd_en;
  logic [2*DATA_WIDTH-1:0] rd_pair;

  assign idle   = (state_q == IDLE);
  assign full   = (count_q == CNT_W'(DEPTH));
  // A flush in the same cycle swallows the write.
  assign wr_acc = bus.wr_valid && idle && !full && !bus.flush;

  // Pairs are stored as {x2, x1}; the read register doubles as lane 1 output.
  nn_feeder_mem #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DATA_WIDTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data ({bus.wr_data2, bus.wr_data1}),
    .rd_en   (rd_en),
    .rd_addr (strm_ptr_q),
    .rd_data (rd_pair)
  );

  // Next-state logic: FSM, pointers, occupancy, lane-2 skew and done pulse.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    strm_ptr_d = strm_ptr_q;
    count_d    = count_q;
    beats_d    = beats_q;
    valid1_d   = 1'b0;
    done_d     = 1'b0;
    rd_en      = 1'b0;
    // Lane 2 trails lane 1 by one cycle: capture x2 of the beat just shown.
    valid2_d   = valid1_q;
    data2_d    = valid1_q ? rd_pair[2*DATA_WIDTH-1:DATA_WIDTH] : data2_q;

    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else begin
          if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
          end
          // Stream length is the occupancy before any same-cycle write.
          if (bus.start) begin
            beats_d    = count_q;
            strm_ptr_d = rd_ptr_q;
            state_d    = (count_q == '0) ? DONE : STREAM;
          end
        end
      end

      STREAM: begin
        rd_en      = 1'b1;
        valid1_d   = 1'b1;
        strm_ptr_d = strm_ptr_q + 1'b1;
        beats_d    = beats_q - 1'b1;
`ifdef NN_FEEDER_REPLAY_EN
        // Replay keeps the head where it is; strm_ptr is reloaded per stream.
        rd_ptr_d   = rd_ptr_q;
`else
        rd_ptr_d   = rd_ptr_q + 1'b1;
        count_d    = count_q - 1'b1;
`endif
        if (beats_q == CNT_W'(1)) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        state_d = DONE;
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      strm_ptr_q <= '0;
      count_q    <= '0;
      beats_q    <= '0;
      valid1_q   <= 1'b0;
      valid2_q   <= 1'b0;
      done_q     <= 1'b0;
      data2_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      strm_ptr_q <= strm_ptr_d;
      count_q    <= count_d;
      beats_q    <= beats_d;
      valid1_q   <= valid1_d;
      valid2_q   <= valid2_d;
      done_q     <= done_d;
      data2_q    <= data2_d;
    end
  end

  assign bus.wr_ready   = idle && !full;
  assign bus.busy       = !idle;
  assign bus.count      = count_q;
  assign bus.done       = done_q;
  assign bus.out_valid1 = valid1_q;
  assign bus.out_data1  = rd_pair[DATA_WIDTH-1:0];
  assign bus.out_valid2 = valid2_q;
  assign bus.out_data2  = data2_q;

endmodule

// File: tb/tb_nn_input_feeder.sv
// tb/tb_nn_input_feeder.sv - self-checking bench for nn_input_feeder with a queue-based reference model
`timescale 1ns/1ps
module tb_nn_input_feeder;

  localparam int DEPTH = 4;
  localparam int DW    = 16;
`ifdef NN_FEEDER_REPLAY_EN
  localparam bit REPLAY = 1'b1;
`else
  localparam bit REPLAY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nn_input_feeder_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

  nn_input_feeder #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [DW-1:0] x1;
    logic [DW-1:0] x2;
  } pair_t;

  pair_t         mbuf[$];
  pair_t         snap[$];
  int            cyc    = 0;
  int            s      = 0;
  int            n      = 0;
  bit            active = 1'b0;
  logic [DW-1:0] last1  = '0;
  logic [DW-1:0] last2  = '0;

  logic          e_v1, e_v2, e_busy, e_done, e_rdy;
  logic [DW-1:0] e_d1, e_d2;
  int            e_cnt;
  bit            chk_en = 1'b0;

  // Busy spans the edge of start through the edge that leaves DONE.
  function automatic bit busy_at(input int c);
    if (!active) return 1'b0;
    return (c >= s) && (c <= s + ((n > 0) ? n + 1 : 0));
  endfunction

  task automatic model_reset();
    mbuf.delete();
    snap.delete();
    active = 1'b0;
    last1  = '0;
    last2  = '0;
    e_v1   = 1'b0;
    e_v2   = 1'b0;
    e_busy = 1'b0;
    e_done = 1'b0;
    e_d1   = '0;
    e_d2   = '0;
    e_cnt  = 0;
    e_rdy  = 1'b1;
  endtask

  always @(posedge clk) begin
    bit    was_idle;
    pair_t p;
    if (rst) begin
      cyc++;
      was_idle = !busy_at(cyc - 1);
      if (was_idle) begin
        if (bus.flush) begin
          mbuf.delete();
        end else begin
          if (bus.start) begin
            s      = cyc;
            n      = mbuf.size();
            snap   = mbuf;
            active = 1'b1;
          end
          if (bus.wr_valid && mbuf.size() < DEPTH) begin
            p.x1 = bus.wr_data1;
            p.x2 = bus.wr_data2;
            mbuf.push_back(p);
          end
        end
      end
      if (active && !REPLAY && cyc >= s + 1 && cyc <= s + n) begin
        void'(mbuf.pop_front());
      end
      e_v1 = active && (cyc >= s + 1) && (cyc <= s + n);
      if (e_v1) last1 = snap[cyc - s - 1].x1;
      e_v2 = active && (n > 0) && (cyc >= s + 2) && (cyc <= s + n + 1);
      if (e_v2) last2 = snap[cyc - s - 2].x2;
      e_d1   = last1;
      e_d2   = last2;
      e_busy = busy_at(cyc);
      e_done = active && (cyc == s + ((n > 0) ? n + 2 : 1));
      e_cnt  = mbuf.size();
      e_rdy  = (mbuf.size() < DEPTH) && !e_busy;
    end
  end

  // Single compare process, half a cycle after each active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid1", 32'(bus.out_valid1), 32'(e_v1));
      check("out_data1",  32'(bus.out_data1),  32'(e_d1));
      check("out_valid2", 32'(bus.out_valid2), 32'(e_v2));
      check("out_data2",  32'(bus.out_data2),  32'(e_d2));
      check("busy",       32'(bus.busy),       32'(e_busy));
      check("done",       32'(bus.done),       32'(e_done));
      check("count",      32'(bus.count),      32'(e_cnt));
      check("wr_ready",   32'(bus.wr_ready),   32'(e_rdy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.wr_valid = 1'b0;
    bus.wr_data1 = '0;
    bus.wr_data2 = '0;
    bus.start    = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic do_write(input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.wr_valid = 1'b1;
    bus.wr_data1 = a;
    bus.wr_data2 = b;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    check("reset_count",    32'(bus.count),    32'd0);
    check("reset_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("reset_busy",     32'(bus.busy),     32'd0);

    // Two pairs: lane 1 at S+1..S+2, lane 2 at S+2..S+3, done at S+4.
    do_write(16'h0100, 16'h0200);
    do_write(16'h0300, 16'hFF00);
    check("count_two", 32'(bus.count), 32'd2);
    do_start();
    tick();
    check("s1_valid1", 32'(bus.out_valid1), 32'd1);
    check("s1_data1",  32'(bus.out_data1),  32'h0100);
    check("s1_valid2", 32'(bus.out_valid2), 32'd0);
    tick();
    check("s2_data1",  32'(bus.out_data1),  32'h0300);
    check("s2_data2",  32'(bus.out_data2),  32'h0200);
    tick();
    check("s3_valid1", 32'(bus.out_valid1), 32'd0);
    check("s3_valid2", 32'(bus.out_valid2), 32'd1);
    check("s3_data2",  32'(bus.out_data2),  32'hFF00);
    tick();
    check("s4_done",   32'(bus.done),  32'd1);
    check("s4_count",  32'(bus.count), REPLAY ? 32'd2 : 32'd0);
    tick();
    do_flush();

    // Overfill: fifth write dropped.
    for (int i = 0; i < 5; i++) begin
      do_write(16'(i * 256 + 16), 16'(i * 256 + 32));
      if (i == 3) begin
        check("full_ready", 32'(bus.wr_ready), 32'd0);
        check("full_count", 32'(bus.count),    32'd4);
      end
    end
    check("overfill_count", 32'(bus.count), 32'd4);
    do_start();
    repeat (4) tick();
    check("last_beat_data1", 32'(bus.out_data1), 32'h0310);
    repeat (4) tick();
    do_flush();

    // Empty start: done one cycle later, no valids.
    do_start();
    check("empty_busy",   32'(bus.busy),       32'd1);
    check("empty_valid1", 32'(bus.out_valid1), 32'd0);
    tick();
    check("empty_done",   32'(bus.done),       32'd1);
    check("empty_busy2",  32'(bus.busy),       32'd0);
    tick();

    // Writes, start and flush during a stream are ignored.
    do_write(16'h0A00, 16'h0B00);
    do_write(16'h0C00, 16'h0D00);
    do_write(16'h0E00, 16'h0F00);
    do_start();
    bus.wr_valid = 1'b1;
    bus.wr_data1 = 16'h7777;
    bus.wr_data2 = 16'h8888;
    bus.start    = 1'b1;
    bus.flush    = 1'b1;
    repeat (3) tick();
    clear_inputs();
    repeat (3) tick();
    check("ignored_count", 32'(bus.count), REPLAY ? 32'd3 : 32'd0);
    do_flush();

`ifdef NN_FEEDER_REPLAY_EN
    do_write(16'h0500, 16'h0600);
    for (int r = 0; r < 2; r++) begin
      do_start();
      tick();
      check("replay_data1", 32'(bus.out_data1), 32'h0500);
      tick();
      check("replay_data2", 32'(bus.out_data2), 32'h0600);
      repeat (2) tick();
      check("replay_count", 32'(bus.count), 32'd1);
    end
    do_flush();
    check("replay_flush_count", 32'(bus.count), 32'd0);
`endif

    // Reset mid-stream at S+2 of a four-pair stream.
    for (int i = 0; i < 4; i++) do_write(16'(16'h1000 + i), 16'(16'h2000 + i));
    do_start();
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_valid1", 32'(bus.out_valid1), 32'd0);
    check("rst_data1",  32'(bus.out_data1),  32'd0);
    check("rst_valid2", 32'(bus.out_valid2), 32'd0);
    check("rst_busy",   32'(bus.busy),       32'd0);
    check("rst_count",  32'(bus.count),      32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("rst_release_ready", 32'(bus.wr_ready), 32'd1);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      bus.wr_valid = 1'($urandom_range(0, 1));
      bus.wr_data1 = 16'($urandom);
      bus.wr_data2 = 16'($urandom);
      bus.start    = ($urandom_range(0, 9) == 0);
      bus.flush    = ($urandom_range(0, 39) == 0);
      tick();
    end
    clear_inputs();
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
